// File: rtl/input_conditioner_pkg.sv
// Shared constants for the snake-game input front end: button channel
// indices and a counter-width helper.
package input_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS = 5;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_CENTER = 4;

  // Width needed to count 0..maxVal-1, never less than one bit.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal > 1) ? $clog2(maxVal) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, Tick-paced stability counter,
// debounced level and a one-cycle press pulse.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic rawButton,
  output logic enabled,
  output logic pressed
);

  localparam int unsigned DW = $clog2(STABLE_TICKS) + 1;
  localparam logic [DW-1:0] LAST = DW'(STABLE_TICKS - 1);

  logic          s0;
  logic          syncLevel;
  logic [DW-1:0] dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0        <= 1'b0;
      syncLevel <= 1'b0;
      dc        <= '0;
      enabled   <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      s0        <= rawButton;
      syncLevel <= s0;
      pressed   <= 1'b0;
      // Any cycle of agreement restarts the count, Tick or not.
      if (syncLevel == enabled) begin
        dc <= '0;
      end else if (tick) begin
        if (dc == LAST) begin
          enabled <= syncLevel;
          pressed <= syncLevel;
          dc      <= '0;
        end else begin
          dc <= dc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Clock divider producing ClockOut and the Tick enable, plus one debounce
// channel per push button, all in the MasterClock domain.
module input_conditioner #(
  parameter int unsigned DIV_HALF     = 2,
  parameter int unsigned STABLE_TICKS = 250000,
  parameter int unsigned NUM_BUTTONS  = input_conditioner_pkg::NUM_BUTTONS
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic [NUM_BUTTONS-1:0] Buttons,
  output logic                   ClockOut,
  output logic                   Tick,
  output logic [NUM_BUTTONS-1:0] Enabled,
  output logic [NUM_BUTTONS-1:0] Pressed
);

  localparam int unsigned CW = input_conditioner_pkg::cntWidth(DIV_HALF);
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      cnt      <= '0;
      ClockOut <= 1'b0;
      Tick     <= 1'b0;
    end else begin
      // Tick is registered alongside the 0->1 toggle so both go high together.
      Tick <= (cnt == LAST) && !ClockOut;
      if (cnt == LAST) begin
        cnt      <= '0;
        ClockOut <= ~ClockOut;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : gChan
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) uChan (
      .clk      (MasterClock),
      .reset    (Reset),
      .tick     (Tick),
      .rawButton(Buttons[g]),
      .enabled  (Enabled[g]),
      .pressed  (Pressed[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: directed tables, hand sequences for debounce corners,
// and random button activity compared with a history-based reference model.
module tb_input_conditioner;

  localparam int unsigned DH = 2;
  localparam int unsigned ST = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset1 = 1'b1;
  logic [4:0] Buttons1 = '0;
  logic       ClockOut1, Tick1;
  logic [4:0] Enabled1, Pressed1;

  logic       Reset2 = 1'b1;
  logic [4:0] Buttons2 = '0;
  logic       ClockOut2, Tick2;
  logic [4:0] Enabled2, Pressed2;

  input_conditioner #(.DIV_HALF(DH), .STABLE_TICKS(ST), .NUM_BUTTONS(5)) dut1 (
    .MasterClock(clk), .Reset(Reset1), .Buttons(Buttons1),
    .ClockOut(ClockOut1), .Tick(Tick1), .Enabled(Enabled1), .Pressed(Pressed1)
  );

  input_conditioner #(.DIV_HALF(1), .STABLE_TICKS(1), .NUM_BUTTONS(5)) dut2 (
    .MasterClock(clk), .Reset(Reset2), .Buttons(Buttons2),
    .ClockOut(ClockOut2), .Tick(Tick2), .Enabled(Enabled2), .Pressed(Pressed2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for dut1. ClockOut/Tick follow from the number of edges
  // since reset; a channel flips once ST Ticks have occurred since the last
  // cycle in which its synchronized input agreed with its level.
  int         n = 0;
  int         cyc = 0;
  int         tickQ[$];
  int         lastAgree[5];
  logic [4:0] s0m = '0, syncm = '0, enm = '0, prm = '0;
  logic       mClk = 1'b0, mTick = 1'b0;

  function automatic int ticksAfter(input int since);
    int c = 0;
    for (int k = tickQ.size() - 1; k >= 0; k--) begin
      if (tickQ[k] <= since) break;
      c++;
    end
    return c;
  endfunction

  task automatic modelEdge(input logic rst, input logic [4:0] btn);
    if (rst) begin
      n = 0; s0m = '0; syncm = '0; enm = '0; prm = '0;
      tickQ.delete();
      for (int i = 0; i < 5; i++) lastAgree[i] = cyc;
    end else begin
      prm = '0;
      if (mTick) tickQ.push_back(cyc);
      for (int i = 0; i < 5; i++) begin
        if (syncm[i] == enm[i]) lastAgree[i] = cyc;
        else if (mTick && ticksAfter(lastAgree[i]) == ST) begin
          enm[i] = syncm[i];
          prm[i] = syncm[i];
          lastAgree[i] = cyc;
        end
      end
      syncm = s0m;
      s0m = btn;
      n++;
    end
    mClk  = ((n / DH) % 2) == 1;
    mTick = (n % (2 * DH)) == DH;
    cyc++;
  endtask

  task automatic step1(input logic rst, input logic [4:0] btn);
    Reset1 = rst;
    Buttons1 = btn;
    @(posedge clk);
    modelEdge(rst, btn);
    #1;
    chk("ClockOut", ClockOut1, mClk);
    chk("Tick", Tick1, mTick);
    chk("Enabled", Enabled1, enm);
    chk("Pressed", Pressed1, prm);
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] btn;
    logic       co;
    logic       tk;
    logic [4:0] en;
    logic [4:0] pr;
  } vec_t;

  vec_t tbl1[8];
  vec_t tbl2[6];

  initial begin
    int tickCount;
    int found;
    int presses;
    int stayed;
    int hold;
    int unsigned ch;
    logic [4:0] cur;

    tbl1[0] = '{1'b1, 5'h00, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl1[1] = '{1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl1[2] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h00, 5'h00};
    tbl1[3] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 5'h00};
    tbl1[4] = '{1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl1[5] = '{1'b0, 5'h00, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl1[6] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h00, 5'h00};
    tbl1[7] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 5'h00};

    tbl2[0] = '{1'b1, 5'h00, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl2[1] = '{1'b0, 5'h1f, 1'b1, 1'b1, 5'h00, 5'h00};
    tbl2[2] = '{1'b0, 5'h1f, 1'b0, 1'b0, 5'h00, 5'h00};
    tbl2[3] = '{1'b0, 5'h1f, 1'b1, 1'b1, 5'h00, 5'h00};
    tbl2[4] = '{1'b0, 5'h1f, 1'b0, 1'b0, 5'h1f, 5'h1f};
    tbl2[5] = '{1'b0, 5'h1f, 1'b1, 1'b1, 5'h1f, 5'h00};

    // Divider pattern after reset, then free run: 10 Ticks in 40 cycles.
    tickCount = 0;
    for (int k = 0; k < 8; k++) begin
      step1(tbl1[k].rst, tbl1[k].btn);
      chk("tblClockOut", ClockOut1, tbl1[k].co);
      chk("tblTick", Tick1, tbl1[k].tk);
      chk("tblEnabled", Enabled1, tbl1[k].en);
      chk("tblPressed", Pressed1, tbl1[k].pr);
      if (k > 0 && Tick1) tickCount++;
    end
    for (int k = 0; k < 33; k++) begin
      step1(1'b0, 5'h00);
      if (Tick1) tickCount++;
    end
    chk("tickCount40", tickCount, 10);

    // Held Left button: one press, latency 15..18 cycles from the raw edge.
    found = 0; presses = 0;
    for (int k = 1; k <= 40; k++) begin
      step1(1'b0, 5'h01);
      if (Enabled1[0] && found == 0) found = k;
      if (Pressed1[0]) presses++;
    end
    chk("leftLatencyInRange", int'(found >= 15 && found <= 18), 1);
    chk("leftPressCount", presses, 1);
    for (int k = 0; k < 25; k++) step1(1'b0, 5'h00);
    chk("leftReleased", Enabled1[0], 0);

    // Short Up pulse spanning fewer than ST Ticks is rejected.
    found = 0;
    for (int k = 0; k < 10; k++) begin
      step1(1'b0, 5'h04);
      if (Enabled1[2] || Pressed1[2]) found++;
    end
    for (int k = 0; k < 30; k++) begin
      step1(1'b0, 5'h00);
      if (Enabled1[2] || Pressed1[2]) found++;
    end
    chk("upGlitchRejected", found, 0);

    // Down held, bounce low for one Tick, then released for good.
    for (int k = 0; k < 25; k++) step1(1'b0, 5'h08);
    chk("downHeld", Enabled1[3], 1);
    stayed = 1; presses = 0;
    for (int k = 0; k < 4; k++) begin
      step1(1'b0, 5'h00);
      if (!Enabled1[3]) stayed = 0;
    end
    for (int k = 0; k < 6; k++) begin
      step1(1'b0, 5'h08);
      if (!Enabled1[3]) stayed = 0;
      if (Pressed1[3]) presses++;
    end
    chk("downSurvivesBounce", stayed, 1);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      step1(1'b0, 5'h00);
      if (!Enabled1[3] && found == 0) found = k;
      if (Pressed1[3]) presses++;
    end
    chk("downReleaseInRange", int'(found >= 15 && found <= 18), 1);
    chk("downNoReleasePulse", presses, 0);

    // Reset mid-operation with buttons held, then fresh presses afterwards.
    for (int k = 0; k < 25; k++) step1(1'b0, 5'h1f);
    chk("allHeld", Enabled1, 5'h1f);
    for (int k = 0; k < 6; k++) step1(1'b0, 5'h15);
    step1(1'b1, 5'h1f);
    chk("resetEnabled", Enabled1, 0);
    chk("resetClockOut", ClockOut1, 0);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      step1(1'b0, 5'h1f);
      if (Enabled1 == 5'h1f && found == 0) begin
        found = k;
        chk("repressPulse", Pressed1, 5'h1f);
      end
    end
    chk("repressLatency", found, 15);

    // Random button activity with occasional resets.
    cur = '0; hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        ch = $urandom_range(4, 0);
        cur[ch] = ~cur[ch];
        hold = $urandom_range(30, 1);
      end
      hold--;
      step1($urandom_range(299, 0) == 0, cur);
    end

    // Fastest configuration: all five buttons at once.
    for (int k = 0; k < 6; k++) begin
      Reset2 = tbl2[k].rst;
      Buttons2 = tbl2[k].btn;
      @(posedge clk);
      #1;
      chk("fastClockOut", ClockOut2, tbl2[k].co);
      chk("fastTick", Tick2, tbl2[k].tk);
      chk("fastEnabled", Enabled2, tbl2[k].en);
      chk("fastPressed", Pressed2, tbl2[k].pr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
